// File: rtl/fetch_pcgen_ras.sv
// Fetch-stage next-PC generator with aligned block requests and cross-boundary fetch.
// Define FETCH_PCGEN_RAS_EN to build the return-address stack for ret prediction.
module fetch_pcgen_ras #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     FETCH_BYTES = 8,
  parameter int unsigned     RAS_DEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                               clk,
  input  logic                               cpurst_n,
  input  logic                               fet_stall,
  input  logic                               flush_valid,
  input  logic [XLEN-1:0]                    flush_pc,
  input  logic                               pd_valid,
  input  logic [1:0]                         pd_kind,
  input  logic [XLEN-1:0]                    pd_target,
  input  logic                               pd_rv16,
  input  logic                               pd_need_next,
  output logic                               req_valid,
  input  logic                               req_ready,
  output logic [XLEN-$clog2(FETCH_BYTES)-1:0] req_addr,
  output logic                               req_cross,
  output logic [XLEN-1:0]                    pc,
  output logic                               ras_empty
);
  localparam int unsigned LOG2FB = $clog2(FETCH_BYTES);
  localparam int unsigned BW     = XLEN - LOG2FB;
  localparam logic [1:0]  KIND_SEQ  = 2'd0;
  localparam logic [1:0]  KIND_CALL = 2'd2;
  localparam logic [1:0]  KIND_RET  = 2'd3;

  if (FETCH_BYTES < 4 || FETCH_BYTES > 64 || RAS_DEPTH < 2 || RAS_DEPTH > 16) begin : g_cfg_check
    $error("fetch_pcgen_ras: unsupported FETCH_BYTES or RAS_DEPTH");
  end

  typedef enum logic [1:0] {BOOT, RUN, CROSS} state_t;

  state_t          state;
  logic [BW-1:0]   fetched_blk;
  logic            flush_pend;
  logic [XLEN-1:0] flush_tgt;

  logic [BW-1:0]   pc_blk;
  logic            accept;
  logic            port_free;
  logic            take_pd;
  logic            go_cross;
  logic [XLEN-1:0] flush_pc_al;
  logic [XLEN-1:0] link_pc;
  logic [XLEN-1:0] pd_next_pc;
  logic            ras_pop;
  logic [XLEN-1:0] ras_top_val;

  assign pc_blk      = pc[XLEN-1:LOG2FB];
  assign accept      = req_valid & req_ready;
  assign port_free   = ~req_valid | req_ready;
  assign flush_pc_al = flush_pc & ~XLEN'(1);
  assign link_pc     = pc + (pd_rv16 ? XLEN'(2) : XLEN'(4));
  // A cross-boundary request may only be launched once the port is free, keeping requests stable.
  assign go_cross    = (state == RUN) & ~flush_valid & ~fet_stall & pd_need_next & port_free;
  assign take_pd     = (state == RUN) & ~flush_valid & ~fet_stall & ~pd_need_next & pd_valid;

`ifdef FETCH_PCGEN_RAS_EN
  localparam int unsigned RW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = RW + 1;

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [RW-1:0]   ras_top;
  logic [CW-1:0]   ras_cnt;
  logic            ras_push;

  assign ras_push    = take_pd & (pd_kind == KIND_CALL);
  assign ras_pop     = take_pd & (pd_kind == KIND_RET) & (ras_cnt != '0);
  assign ras_top_val = ras_mem[ras_top];

  // Circular stack: pushing at full wraps the pointer and overwrites the oldest entry.
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      ras_top   <= '0;
      ras_cnt   <= '0;
      ras_empty <= 1'b1;
    end else if (ras_push) begin
      ras_top   <= ras_top + RW'(1);
      ras_empty <= 1'b0;
      if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt <= ras_cnt + CW'(1);
    end else if (ras_pop) begin
      ras_top   <= ras_top - RW'(1);
      ras_cnt   <= ras_cnt - CW'(1);
      ras_empty <= (ras_cnt == CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (ras_push) ras_mem[ras_top + RW'(1)] <= link_pc;
  end
`else
  assign ras_pop     = 1'b0;
  assign ras_top_val = '0;
  assign ras_empty   = 1'b1;
`endif

  // Target of an accepted predecoded instruction.
  always_comb begin
    pd_next_pc = pc;
    if (ras_pop)                    pd_next_pc = ras_top_val;
    else if (pd_kind == KIND_SEQ)   pd_next_pc = link_pc;
    else                            pd_next_pc = pd_target & ~XLEN'(1);
  end

  // Control FSM, PC register and registered request port.
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC & ~XLEN'(1);
      req_valid   <= 1'b1;
      req_addr    <= RESET_PC[XLEN-1:LOG2FB];
      req_cross   <= 1'b0;
      fetched_blk <= RESET_PC[XLEN-1:LOG2FB];
      flush_pend  <= 1'b0;
      flush_tgt   <= '0;
    end else begin
      case (state)
        BOOT: begin
          if (flush_valid) pc <= flush_pc_al;
          if (req_ready) begin
            state       <= RUN;
            req_valid   <= 1'b0;
            fetched_blk <= req_addr;
          end
        end
        RUN: begin
          if (accept) fetched_blk <= req_addr;
          if (flush_valid)  pc <= flush_pc_al;
          else if (take_pd) pc <= pd_next_pc;
          if (go_cross) begin
            state     <= CROSS;
            req_valid <= 1'b1;
            req_addr  <= pc_blk + BW'(1);
            req_cross <= 1'b1;
          end else if (port_free) begin
            req_valid <= (pc_blk != (accept ? req_addr : fetched_blk));
            req_addr  <= pc_blk;
          end
        end
        CROSS: begin
          // A flush arriving while the second-half request waits is applied on acceptance.
          if (req_ready) begin
            state      <= RUN;
            req_valid  <= 1'b0;
            req_cross  <= 1'b0;
            req_addr   <= pc_blk;
            flush_pend <= 1'b0;
            if (flush_valid)     pc <= flush_pc_al;
            else if (flush_pend) pc <= flush_tgt;
          end else if (flush_valid) begin
            flush_pend <= 1'b1;
            flush_tgt  <= flush_pc_al;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_pcgen_ras.sv
// Directed plus randomized bench for fetch_pcgen_ras against a queue-based reference model.
module tb_fetch_pcgen_ras;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned LOG2FB = 3;
  localparam int unsigned BW     = XLEN - LOG2FB;
  localparam int unsigned DEPTH  = 4;

  logic            clk = 1'b0;
  logic            cpurst_n;
  logic            fet_stall, flush_valid, pd_valid, pd_rv16, pd_need_next, req_ready;
  logic [31:0]     flush_pc, pd_target;
  logic [1:0]      pd_kind;
  logic            req_valid, req_cross, ras_empty;
  logic [BW-1:0]   req_addr;
  logic [31:0]     pc;

  int tests  = 0;
  int failed = 0;

  fetch_pcgen_ras #(.XLEN(XLEN), .FETCH_BYTES(8), .RAS_DEPTH(DEPTH), .RESET_PC(32'h100)) dut (
    .clk(clk), .cpurst_n(cpurst_n), .fet_stall(fet_stall), .flush_valid(flush_valid),
    .flush_pc(flush_pc), .pd_valid(pd_valid), .pd_kind(pd_kind), .pd_target(pd_target),
    .pd_rv16(pd_rv16), .pd_need_next(pd_need_next), .req_valid(req_valid),
    .req_ready(req_ready), .req_addr(req_addr), .req_cross(req_cross), .pc(pc),
    .ras_empty(ras_empty)
  );

  always #5 clk = ~clk;

  // Reference model: the fetch PC, whether booting or waiting on a second-half fetch,
  // the request port contents, the last fetched block and a deferred flush.
  logic [31:0]   m_pc, m_ftgt;
  logic          m_boot, m_cross, m_rv, m_rc, m_fpend;
  logic [BW-1:0] m_ra, m_fblk;
`ifdef FETCH_PCGEN_RAS_EN
  logic [31:0]   ras_q[$];
`endif

  function automatic logic [BW-1:0] blk(input logic [31:0] a);
    return a[31:LOG2FB];
  endfunction

  task automatic model_reset();
    m_pc = 32'h100; m_boot = 1'b1; m_cross = 1'b0; m_rv = 1'b1; m_ra = blk(32'h100);
    m_rc = 1'b0; m_fblk = blk(32'h100); m_fpend = 1'b0; m_ftgt = '0;
`ifdef FETCH_PCGEN_RAS_EN
    ras_q.delete();
`endif
  endtask

  function automatic logic exp_ras_empty();
`ifdef FETCH_PCGEN_RAS_EN
    return ras_q.size() == 0;
`else
    return 1'b1;
`endif
  endfunction

  // Where the PC goes after an accepted predecoded instruction; updates the stack.
  task automatic pd_eval(output logic [31:0] npc);
    logic [31:0] link;
    link = m_pc + (pd_rv16 ? 32'd2 : 32'd4);
    npc  = pd_target & ~32'h1;
    if (pd_kind == 2'd0) npc = link;
`ifdef FETCH_PCGEN_RAS_EN
    if (pd_kind == 2'd2) begin
      if (ras_q.size() == DEPTH) void'(ras_q.pop_back());
      ras_q.push_front(link);
    end
    if (pd_kind == 2'd3 && ras_q.size() > 0) npc = ras_q.pop_front();
`endif
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [31:0]   fpc, npc;
    logic          busy, enter_cross;
    logic [BW-1:0] newf;
    fpc = flush_pc & ~32'h1;
    if (m_boot) begin
      if (flush_valid) m_pc = fpc;
      if (req_ready) begin m_boot = 1'b0; m_rv = 1'b0; m_fblk = m_ra; end
    end else if (m_cross) begin
      if (req_ready) begin
        m_cross = 1'b0; m_rv = 1'b0; m_rc = 1'b0;
        if (flush_valid) m_pc = fpc;
        else if (m_fpend) m_pc = m_ftgt;
        m_fpend = 1'b0;
      end else if (flush_valid) begin
        m_fpend = 1'b1; m_ftgt = fpc;
      end
    end else begin
      busy = m_rv && !req_ready;
      newf = (m_rv && req_ready) ? m_ra : m_fblk;
      npc = m_pc;
      enter_cross = 1'b0;
      if (flush_valid) npc = fpc;
      else if (!fet_stall) begin
        if (pd_need_next) enter_cross = !busy;
        else if (pd_valid) pd_eval(npc);
      end
      if (enter_cross) begin
        m_cross = 1'b1; m_rv = 1'b1; m_ra = blk(m_pc) + BW'(1); m_rc = 1'b1;
      end else if (!busy) begin
        m_rv = (blk(m_pc) != newf); m_ra = blk(m_pc);
      end
      m_fblk = newf;
      m_pc = npc;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("pc", pc, m_pc);
    check("req_valid", 32'(req_valid), 32'(m_rv));
    if (m_rv) check("req_addr", 32'(req_addr), 32'(m_ra));
    check("req_cross", 32'(req_cross), 32'(m_rc));
    check("ras_empty", 32'(ras_empty), 32'(exp_ras_empty()));
  endtask

  task automatic drive(input logic fv, input logic [31:0] fpc, input logic st, input logic nn,
                       input logic pv, input logic [1:0] k, input logic [31:0] tgt,
                       input logic r16, input logic rdy);
    flush_valid = fv; flush_pc = fpc; fet_stall = st; pd_need_next = nn; pd_valid = pv;
    pd_kind = k; pd_target = tgt; pd_rv16 = r16; req_ready = rdy;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic step(input logic fv, input logic [31:0] fpc, input logic st, input logic nn,
                      input logic pv, input logic [1:0] k, input logic [31:0] tgt,
                      input logic r16, input logic rdy);
    drive(fv, fpc, st, nn, pv, k, tgt, r16, rdy);
    cycle();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, rdy);
  endtask

  task automatic pd(input logic [1:0] k, input logic [31:0] tgt, input logic r16);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, k, tgt, r16, 1'b1);
  endtask

  task automatic flush(input logic [31:0] fpc);
    step(1'b1, fpc, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    cpurst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    model_reset();
    #12;
    compare_all();
    check("rst_pc", pc, 32'h100);
    check("rst_req_addr", 32'(req_addr), 32'h20);
    cpurst_n = 1'b1;

    // Boot request accepted, then two sequential 32-bit instructions.
    idle(1'b1);
    pd(2'd0, 32'h0, 1'b0);
    check("seq1_pc", pc, 32'h104);
    pd(2'd0, 32'h0, 1'b0);
    check("seq2_pc", pc, 32'h108);
    idle(1'b0);
    check("newblk_req_valid", 32'(req_valid), 32'h1);
    check("newblk_req_addr", 32'(req_addr), 32'h21);
    idle(1'b1);

    // Cross-boundary instruction at 0x106 with the second-half request held for 3 cycles.
    step(1'b1, 32'h106, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("cross_addr", 32'(req_addr), 32'h21);
      check("cross_flag", 32'(req_cross), 32'h1);
      check("cross_pc", pc, 32'h106);
      idle(1'b0);
    end
    idle(1'b1);
    check("cross_done", 32'(req_cross), 32'h0);

`ifdef FETCH_PCGEN_RAS_EN
    // Call from 0x200 (16-bit) then ret at 0x410.
    flush(32'h200); idle(1'b1); idle(1'b1);
    pd(2'd2, 32'h400, 1'b1);
    check("call_pc", pc, 32'h400);
    flush(32'h410);
    pd(2'd3, 32'h0, 1'b0);
    check("ret_pc", pc, 32'h202);
    check("ret_empty", 32'(ras_empty), 32'h1);

    // Five nested calls overflow a 4-deep stack; five rets drain it.
    flush(32'h1000);
    for (int i = 0; i < 5; i++) pd(2'd2, 32'h2000 + 32'(i) * 32'h1000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pd(2'd3, 32'h7770, 1'b0);
      check("ret_pop_pc", pc, 32'h5004 - 32'(i) * 32'h1000);
    end
    pd(2'd3, 32'h7770, 1'b0);
    check("ret_underflow_pc", pc, 32'h7770);
    pd(2'd2, 32'h9000, 1'b0);
    pd(2'd3, 32'h0, 1'b0);
    check("b2b_call_ret_pc", pc, 32'h7774);
`else
    pd(2'd2, 32'h300, 1'b0);
    pd(2'd3, 32'h500, 1'b0);
    check("noras_ret_pc", pc, 32'h500);
    check("noras_empty", 32'(ras_empty), 32'h1);
`endif

    // Flush beats stall and pd; request follows once the PC is in the new block.
    idle(1'b1); idle(1'b1); idle(1'b1);
    step(1'b1, 32'h803, 1'b1, 1'b0, 1'b1, 2'd2, 32'h444, 1'b0, 1'b1);
    check("flush_pc", pc, 32'h802);
    idle(1'b0);
    check("flush_req_valid", 32'(req_valid), 32'h1);
    check("flush_req_addr", 32'(req_addr), 32'h100);

    // Randomized traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        cpurst_n = 1'b0;
        #2;
        model_reset();
        compare_all();
        cpurst_n = 1'b1;
      end
      drive($urandom_range(0, 15) == 0, 32'($urandom_range(0, 32'h1fff)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
            32'($urandom_range(0, 32'h1fff)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/fetch_pcgen_ras.md
# fetch_pcgen_ras

Parametrised next-PC generator for the fetch stage. It holds the architectural fetch PC and selects the next PC from backend flushes, predecoded control flow and sequential advance. It issues aligned fetch-block requests to instruction memory over a valid/ready handshake, including the extra request for instructions that cross a block boundary. An optional return-address stack predicts `ret` targets. It sits between the instruction SRAM port and the decode stage.

## Interface
Parameters:
- XLEN, 32, address/PC width.
- FETCH_BYTES, 8, fetch block size in bytes; power of two, 4..64; LOG2FB = log2(FETCH_BYTES).
- RAS_DEPTH, 4, return-address-stack entries; power of two, 2..16.
- RESET_PC, 32'h0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state on rising edge.
- cpurst_n  in  1  reset, asynchronous assert, active-low.
- fet_stall  in  1  hold PC and RAS; no new pd consumption.
- flush_valid  in  1  backend redirect (trap, mret, mispredict); highest priority.
- flush_pc  in  XLEN  redirect target.
- pd_valid  in  1  instruction at `pc` predecoded and accepted by decode this cycle.
- pd_kind  in  2  0 seq, 1 jump/taken-branch, 2 call, 3 ret.
- pd_target  in  XLEN  predecoded target (valid for kind 1–3).
- pd_rv16  in  1  instruction at `pc` is 16-bit.
- pd_need_next  in  1  instruction at `pc` spans into the next block; pd_valid is ignored while high.
- req_valid  out  1  fetch request valid.
- req_ready  in  1  instruction memory accepts the request.
- req_addr  out  XLEN-LOG2FB  block address, pc[XLEN-1:LOG2FB] or +1.
- req_cross  out  1  request is the second half of a cross-boundary fetch.
- pc  out  XLEN  current fetch PC; bit 0 always 0.
- ras_empty  out  1  RAS count == 0 (RAS builds only).

## Operation
- States: BOOT, RUN, CROSS.
- BOOT:
  - Entered on reset.
  - req_valid=1, req_addr=RESET_PC block, req_cross=0.
  - On req_ready, go to RUN.
- RUN, next-PC priority:
  1. flush_valid → flush_pc.
  2. fet_stall → hold.
  3. pd_need_next → go to CROSS; pc holds.
  4. pd_valid with kind 3 and RAS non-empty → RAS top.
  5. pd_valid with kind 1, 2 or 3 → pd_target.
  6. pd_valid with kind 0 → pc + (pd_rv16 ? 2 : 4).
  7. Otherwise hold.
  - Arithmetic is modulo 2^XLEN; flush_pc[0] is forced to 0.
- Request generation:
  - fetched_blk register holds the last accepted block.
  - In RUN, req_valid=1 whenever pc[XLEN-1:LOG2FB] != fetched_blk.
  - req_addr = pc block while in RUN.
- CROSS:
  - req_valid=1, req_addr=pc block+1, req_cross=1.
  - On req_ready, return to RUN; fetched_blk is unchanged.
  - flush_valid aborts to RUN only if no request is pending; otherwise the flush target is latched and applied on acceptance.
- Handshake: once req_valid is high, req_addr, req_cross and req_valid stay stable until req_ready. This holds through fet_stall and flush; a flush takes effect on the next request.
- RAS (circular buffer, top pointer plus count 0..RAS_DEPTH):
  - Call push: pushes pc + (pd_rv16 ? 2 : 4). At full, the pointer wraps, the oldest entry is overwritten and count stays RAS_DEPTH.
  - Ret pop: pops. When empty, no pop occurs and pd_target is used.
  - Updates only on a pd_valid that is accepted in RUN without flush or stall.
  - flush does not alter the RAS.

## Timing
- Reset values: pc=RESET_PC; state=BOOT; req_valid=1; req_addr=RESET_PC[XLEN-1:LOG2FB]; req_cross=0; fetched_blk=RESET_PC block; RAS count=0; ras_empty=1.
- Reset mid-handshake drops the request immediately; BOOT re-requests.
- pc updates one cycle after the qualifying pd_valid or flush.
- req_valid/req_addr are registered and rise one cycle after pc enters a new block. Flush-to-request latency is 1 cycle when the port is idle.
- Same-cycle RAS push and wrap resolve within one cycle. A back-to-back call then ret returns the just-pushed address.

## Configuration
- `FETCH_PCGEN_RAS_EN` defined: RAS instantiated; kind 3 uses the RAS top when non-empty; ras_empty present.
- Undefined: no RAS storage; kind 2 behaves as kind 1 and kind 3 always uses pd_target; ras_empty is tied to 1.

## Test plan
- Reset with RESET_PC=0x100 and req_ready=1 → BOOT request with addr 0x20, RUN next cycle; pd kind 0 ×2 (rv32) → pc 0x104, then 0x108 with req_addr 0x21.
- pc=0x106, pd_need_next with req_ready low for 3 cycles → CROSS, req_addr=0x21 held stable with req_cross=1, pc stays 0x106; ready → RUN.
- Call at 0x200 (rv16, target 0x400), then ret at 0x410 (pd_target 0x0) → push 0x202, pc=0x202 after the ret, ras_empty=1.
- 5 calls with RAS_DEPTH=4 and then 5 rets → first 4 pops return the last 4 link addresses newest first; 5th ret uses pd_target.
- flush_valid, pd_valid and fet_stall asserted together, flush_pc=0x803 → pc=0x802, no RAS change; request for block 0x100 the next cycle.
- Build without FETCH_PCGEN_RAS_EN: call then ret with pd_target=0x500 → pc=0x500; ras_empty stays 1.
